// File: rtl/copro_bridge_pkg.sv
// Shared definitions for the coprocessor FIFO bridge: header layout,
// ingress states and status word bit positions.
package copro_bridge_pkg;

    localparam int CH_ID_MSB = 31;
    localparam int CH_ID_LSB = 28;
    localparam int LEN_MSB   = 15;
    localparam int LEN_LSB   = 0;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_PAY  = 2'd1,
        ST_EMIT = 2'd2,
        ST_DROP = 2'd3
    } in_state_e;

    localparam int STAT_STATE_LSB   = 0;
    localparam int STAT_BUSY_BIT    = 2;
    localparam int STAT_ERR_BIT     = 3;
    localparam int STAT_GNT_LSB     = 4;
    localparam int STAT_IN_CNT_LSB  = 8;
    localparam int STAT_OUT_CNT_LSB = 16;

    // Index width that stays legal for a single-entry range.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants only from idle, holds the grant while hold=1,
// and drops to idle for one cycle on release before re-arbitrating.
module rr_arbiter
    import copro_bridge_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IW     = idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req,
    input  logic              hold,
    output logic [NUM_CH-1:0] gnt,
    output logic [IW-1:0]     gnt_idx
);

    logic [NUM_CH-1:0] gnt_q;
    logic [NUM_CH-1:0] pick;
    logic [IW-1:0]     pick_idx;
    logic [IW-1:0]     last_q;
    logic [IW-1:0]     idx_q;
    logic              found;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (last_q == IW'(j)) begin
                for (int i = 1; i <= NUM_CH; i++) begin
                    if (!found && req[(j + i) % NUM_CH]) begin
                        found                   = 1'b1;
                        pick[(j + i) % NUM_CH]  = 1'b1;
                        pick_idx                = IW'((j + i) % NUM_CH);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q  <= '0;
            last_q <= IW'(NUM_CH - 1);
            idx_q  <= '0;
        end else if (|gnt_q) begin
            if (!hold) gnt_q <= '0;
        end else begin
            gnt_q <= pick;
            if (found) begin
                last_q <= pick_idx;
                idx_q  <= pick_idx;
            end
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;

endmodule

// File: rtl/copro_fifo_bridge.sv
// Coprocessor endpoint of the HPS FIFO pair: framed ingress packets are packed
// into wide per-channel beats; channel results are arbitrated onto the egress FIFO.
//
// state | meaning
// HDR   | read one header word, decode channel id and payload length
// PAY   | read payload words into lanes of the current beat
// EMIT  | present the beat to the selected channel, no FIFO reads
// DROP  | read and discard the payload of a packet with a bad channel id
module copro_fifo_bridge
    import copro_bridge_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 128
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    input  logic [31:0]          fifo_to_copro_out_readdata,
    output logic                 fifo_to_copro_out_read,
    input  logic                 fifo_to_copro_out_waitrequest,
    output logic [31:0]          fifo_to_hps_in_writedata,
    output logic                 fifo_to_hps_in_write,
    input  logic                 fifo_to_hps_in_waitrequest,
    output logic [DATA_W-1:0]    ch_in_data,
    output logic [DATA_W/32-1:0] ch_in_keep,
    output logic                 ch_in_last,
    output logic [NUM_CH-1:0]    ch_in_valid,
    input  logic [NUM_CH-1:0]    ch_in_ready,
    input  logic [NUM_CH*32-1:0] ch_out_data,
    input  logic [NUM_CH-1:0]    ch_out_last,
    input  logic [NUM_CH-1:0]    ch_out_valid,
    output logic [NUM_CH-1:0]    ch_out_ready,
    output logic [31:0]          status
);

    localparam int PACK = DATA_W / 32;
    localparam int IW   = idx_w(NUM_CH);
    localparam int LW   = idx_w(PACK + 1);

    // Every handshake stays quiet during reset and the cycle right after it.
    logic run_q;
    logic active;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) run_q <= 1'b0;
        else             run_q <= 1'b1;
    end

    assign active = run_q && !reset_reset;

    in_state_e         state_q, state_d;
    logic [IW-1:0]     id_q;
    logic [15:0]       rem_q;
    logic [LW-1:0]     lane_q;
    logic [DATA_W-1:0] data_q;
    logic [PACK-1:0]   keep_q;
    logic              err_q;
    logic [7:0]        pkt_in_q;
    logic [7:0]        pkt_out_q;
    logic [NUM_CH-1:0] ch_sel;
    logic [3:0]        hdr_id;
    logic [15:0]       hdr_len;
    logic              hdr_bad;
    logic              rd_xfer;
    logic              beat_acc;
    logic              last_word_in;

    assign hdr_id       = fifo_to_copro_out_readdata[CH_ID_MSB:CH_ID_LSB];
    assign hdr_len      = fifo_to_copro_out_readdata[LEN_MSB:LEN_LSB];
    assign hdr_bad      = {1'b0, hdr_id} >= 5'(NUM_CH);
    assign last_word_in = (rem_q == 16'd1);

    assign fifo_to_copro_out_read = active && (state_q != ST_EMIT);
    assign rd_xfer  = fifo_to_copro_out_read && !fifo_to_copro_out_waitrequest;
    assign beat_acc = active && (state_q == ST_EMIT) && |(ch_sel & ch_in_ready);

    always_comb begin
        ch_sel = '0;
        for (int i = 0; i < NUM_CH; i++) ch_sel[i] = (id_q == IW'(i));
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) state_q <= ST_HDR;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        ch_in_valid = '0;
        ch_in_data  = '0;
        ch_in_keep  = '0;
        ch_in_last  = 1'b0;
        case (state_q)
            ST_HDR: begin
                if (rd_xfer && hdr_len != 16'd0) state_d = hdr_bad ? ST_DROP : ST_PAY;
            end
            ST_PAY: begin
                if (rd_xfer && (lane_q == LW'(PACK - 1) || last_word_in)) state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (active) begin
                    ch_in_valid = ch_sel;
                    ch_in_data  = data_q;
                    ch_in_keep  = keep_q;
                    ch_in_last  = (rem_q == 16'd0);
                end
                if (beat_acc) state_d = (rem_q != 16'd0) ? ST_PAY : ST_HDR;
            end
            ST_DROP: begin
                if (rd_xfer && last_word_in) state_d = ST_HDR;
            end
            default: state_d = ST_HDR;
        endcase
    end

    // Beat assembly; unfilled lanes stay zero because the beat is cleared on each start.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            id_q     <= '0;
            rem_q    <= '0;
            lane_q   <= '0;
            data_q   <= '0;
            keep_q   <= '0;
            err_q    <= 1'b0;
            pkt_in_q <= '0;
        end else begin
            case (state_q)
                ST_HDR: if (rd_xfer) begin
                    id_q   <= IW'(hdr_id);
                    rem_q  <= hdr_len;
                    lane_q <= '0;
                    data_q <= '0;
                    keep_q <= '0;
                    if (hdr_len != 16'd0 && hdr_bad) err_q <= 1'b1;
                end
                ST_PAY: if (rd_xfer) begin
                    for (int l = 0; l < PACK; l++) begin
                        if (lane_q == LW'(l)) begin
                            data_q[32*l +: 32] <= fifo_to_copro_out_readdata;
                            keep_q[l]          <= 1'b1;
                        end
                    end
                    lane_q <= lane_q + LW'(1);
                    rem_q  <= rem_q - 16'd1;
                end
                ST_EMIT: if (beat_acc) begin
                    lane_q <= '0;
                    data_q <= '0;
                    keep_q <= '0;
                    if (rem_q == 16'd0) pkt_in_q <= pkt_in_q + 8'd1;
                end
                ST_DROP: if (rd_xfer) begin
                    rem_q <= rem_q - 16'd1;
                    if (last_word_in) pkt_in_q <= pkt_in_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

    logic [NUM_CH-1:0] gnt;
    logic [IW-1:0]     gnt_idx;
    logic [31:0]       eg_word;
    logic              eg_last;
    logic              eg_busy;
    logic              eg_xfer;
    logic              eg_release;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IW     (IW)
    ) u_arb (
        .clk     (clk_clk),
        .reset   (reset_reset),
        .req     (ch_out_valid),
        .hold    (!eg_release),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        eg_word = '0;
        eg_last = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt[i]) begin
                eg_word = eg_word | ch_out_data[32*i +: 32];
                eg_last = eg_last | ch_out_last[i];
            end
        end
    end

    assign eg_busy                  = |gnt;
    assign fifo_to_hps_in_write     = active && |(ch_out_valid & gnt);
    assign fifo_to_hps_in_writedata = active ? eg_word : 32'd0;
    assign ch_out_ready             = (active && !fifo_to_hps_in_waitrequest) ? gnt : '0;
    assign eg_xfer                  = fifo_to_hps_in_write && !fifo_to_hps_in_waitrequest;
    assign eg_release               = eg_xfer && eg_last;

    always_ff @(posedge clk_clk) begin
        if (reset_reset)     pkt_out_q <= '0;
        else if (eg_release) pkt_out_q <= pkt_out_q + 8'd1;
    end

    always_comb begin
        status = '0;
        status[STAT_STATE_LSB +: 2]   = state_q;
        status[STAT_BUSY_BIT]         = eg_busy;
        status[STAT_ERR_BIT]          = err_q;
        status[STAT_GNT_LSB +: 4]     = 4'(gnt_idx);
        status[STAT_IN_CNT_LSB +: 8]  = pkt_in_q;
        status[STAT_OUT_CNT_LSB +: 8] = pkt_out_q;
    end

endmodule

// File: tb/tb_copro_fifo_bridge.sv
// Directed bench for copro_fifo_bridge: ingress packing/drop/backpressure,
// egress round-robin and stall handling, reset behaviour.
module tb_copro_fifo_bridge;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 128;
    localparam int PACK   = DATA_W / 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [31:0]          rd_data;
    logic                 rd;
    logic                 rd_wait;
    logic [31:0]          wr_data;
    logic                 wr;
    logic                 wr_wait;
    logic [DATA_W-1:0]    ch_in_data;
    logic [PACK-1:0]      ch_in_keep;
    logic                 ch_in_last;
    logic [NUM_CH-1:0]    ch_in_valid;
    logic [NUM_CH-1:0]    ch_in_ready;
    logic [NUM_CH*32-1:0] ch_out_data;
    logic [NUM_CH-1:0]    ch_out_last;
    logic [NUM_CH-1:0]    ch_out_valid;
    logic [NUM_CH-1:0]    ch_out_ready;
    logic [31:0]          status;

    int checks   = 0;
    int failures = 0;

    copro_fifo_bridge #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clk_clk                       (clk),
        .reset_reset                   (rst),
        .fifo_to_copro_out_readdata    (rd_data),
        .fifo_to_copro_out_read        (rd),
        .fifo_to_copro_out_waitrequest (rd_wait),
        .fifo_to_hps_in_writedata      (wr_data),
        .fifo_to_hps_in_write          (wr),
        .fifo_to_hps_in_waitrequest    (wr_wait),
        .ch_in_data                    (ch_in_data),
        .ch_in_keep                    (ch_in_keep),
        .ch_in_last                    (ch_in_last),
        .ch_in_valid                   (ch_in_valid),
        .ch_in_ready                   (ch_in_ready),
        .ch_out_data                   (ch_out_data),
        .ch_out_last                   (ch_out_last),
        .ch_out_valid                  (ch_out_valid),
        .ch_out_ready                  (ch_out_ready),
        .status                        (status)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]        ch;
        logic [DATA_W-1:0] data;
        logic [PACK-1:0]   keep;
        logic              last;
    } beat_t;

    beat_t       beat_q[$];
    beat_t       mon_b;
    logic [31:0] wr_q[$];
    int          valid_cycles = 0;
    int          onehot_bad   = 0;

    always @(negedge clk) begin
        if (ch_in_valid != '0) valid_cycles++;
        if (!$onehot0(ch_in_valid)) onehot_bad++;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_in_valid[i] && ch_in_ready[i]) begin
                mon_b.ch   = 4'(i);
                mon_b.data = ch_in_data;
                mon_b.keep = ch_in_keep;
                mon_b.last = ch_in_last;
                beat_q.push_back(mon_b);
            end
        end
        if (wr && !wr_wait) wr_q.push_back(wr_data);
    end

    logic [31:0] src_w [NUM_CH][3];
    int          src_n [NUM_CH];
    int          src_p [NUM_CH];

    task automatic drive_src();
        for (int i = 0; i < NUM_CH; i++) begin
            ch_out_valid[i] = 1'b0;
            ch_out_last[i]  = 1'b0;
            ch_out_data[32*i +: 32] = 32'd0;
            if (src_p[i] < src_n[i]) begin
                ch_out_valid[i] = 1'b1;
                ch_out_last[i]  = (src_p[i] == src_n[i] - 1);
                ch_out_data[32*i +: 32] = src_w[i][src_p[i]];
            end
        end
    endtask

    function automatic bit src_done();
        for (int i = 0; i < NUM_CH; i++) if (src_p[i] < src_n[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic reset_dut();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic fifo_send(input logic [31:0] w);
        int n = 0;
        rd_data = w;
        rd_wait = 1'b0;
        @(negedge clk);
        while (!rd && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rd) begin
            checks++;
            failures++;
            $display("FAIL fifo_send_timeout word=%08h read=%b expected read=1", w, rd);
            rd_wait = 1'b1;
            return;
        end
        @(posedge clk);
        #1 rd_wait = 1'b1;
    endtask

    task automatic run_egress(input int stall_after, input int stall_len,
                              input logic [31:0] held_exp, output int held_bad);
        int stall_left = 0;
        bit stalled = 1'b0;
        bit adv [NUM_CH];
        held_bad = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (src_done()) break;
            @(negedge clk);
            if (stall_left > 0) begin
                if (wr !== 1'b1 || wr_data !== held_exp || ch_out_ready !== '0 ||
                    status[7:4] !== 4'd1 || status[2] !== 1'b1) held_bad++;
            end
            for (int i = 0; i < NUM_CH; i++) adv[i] = ch_out_valid[i] && ch_out_ready[i];
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_CH; i++) if (adv[i]) src_p[i]++;
            drive_src();
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) wr_wait = 1'b0;
            end else if (!stalled && stall_len > 0 && wr_q.size() == stall_after) begin
                stalled    = 1'b1;
                stall_left = stall_len;
                wr_wait    = 1'b1;
            end
        end
        if (!src_done()) begin
            checks++;
            failures++;
            $display("FAIL egress_timeout sources not drained, writes=%0d", wr_q.size());
        end
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if (rd !== 1'b0 || wr !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes read=%b write=%b expected 0 0", rd, wr);
        end
        checks++;
        if (ch_in_valid !== '0 || ch_out_ready !== '0) begin
            failures++;
            $display("FAIL reset_valid_ready valid=%b ready=%b expected 0", ch_in_valid, ch_out_ready);
        end
        checks++;
        if (ch_in_data !== '0 || ch_in_keep !== '0 || ch_in_last !== 1'b0 || wr_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_data data=%h keep=%b last=%b wdata=%h expected 0",
                     ch_in_data, ch_in_keep, ch_in_last, wr_data);
        end
        checks++;
        if (status !== 32'd0) begin
            failures++;
            $display("FAIL reset_status got=%08h expected 00000000", status);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rd !== 1'b1) begin
            failures++;
            $display("FAIL hdr_read_idle read=%b expected 1", rd);
        end
    endtask

    task automatic test_ingress_pack();
        int vc0;
        ch_in_ready = 4'b0010;
        beat_q.delete();
        vc0 = valid_cycles;
        fifo_send(32'h1000_0005);
        for (int k = 1; k <= 5; k++) fifo_send(32'(k));
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (beat_q.size() !== 2) begin
            failures++;
            $display("FAIL pack_beat_count got=%0d expected 2", beat_q.size());
        end
        if (beat_q.size() >= 2) begin
            checks++;
            if (beat_q[0].ch !== 4'd1 || beat_q[0].data !== 128'h00000004_00000003_00000002_00000001 ||
                beat_q[0].keep !== 4'b1111 || beat_q[0].last !== 1'b0) begin
                failures++;
                $display("FAIL pack_beat0 ch=%0d data=%h keep=%b last=%b expected ch=1 data=4,3,2,1 keep=1111 last=0",
                         beat_q[0].ch, beat_q[0].data, beat_q[0].keep, beat_q[0].last);
            end
            checks++;
            if (beat_q[1].ch !== 4'd1 || beat_q[1].data !== 128'h5 ||
                beat_q[1].keep !== 4'b0001 || beat_q[1].last !== 1'b1) begin
                failures++;
                $display("FAIL pack_beat1 ch=%0d data=%h keep=%b last=%b expected ch=1 data=5 keep=0001 last=1",
                         beat_q[1].ch, beat_q[1].data, beat_q[1].keep, beat_q[1].last);
            end
        end
        checks++;
        if (valid_cycles - vc0 !== 2) begin
            failures++;
            $display("FAIL pack_valid_cycles got=%0d expected 2", valid_cycles - vc0);
        end
        checks++;
        if (status[15:8] !== 8'd1 || status[1:0] !== 2'd0) begin
            failures++;
            $display("FAIL pack_status pkt_in=%0d state=%0d expected 1 0", status[15:8], status[1:0]);
        end
    endtask

    task automatic test_drop();
        int vc0;
        ch_in_ready = 4'b1111;
        beat_q.delete();
        vc0 = valid_cycles;
        fifo_send(32'h7000_0002);
        checks++;
        if (status[1:0] !== 2'd3 || status[3] !== 1'b1) begin
            failures++;
            $display("FAIL drop_enter state=%0d err=%b expected 3 1", status[1:0], status[3]);
        end
        fifo_send(32'h0000_AAAA);
        fifo_send(32'h0000_BBBB);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (valid_cycles - vc0 !== 0 || beat_q.size() !== 0) begin
            failures++;
            $display("FAIL drop_no_valid valid_cycles=%0d beats=%0d expected 0 0", valid_cycles - vc0, beat_q.size());
        end
        checks++;
        if (status[1:0] !== 2'd0 || status[3] !== 1'b1 || status[15:8] !== 8'd2) begin
            failures++;
            $display("FAIL drop_status state=%0d err=%b pkt_in=%0d expected 0 1 2",
                     status[1:0], status[3], status[15:8]);
        end
        ch_in_ready = 4'b0001;
        fifo_send(32'h0000_0002);
        fifo_send(32'h0000_0011);
        fifo_send(32'h0000_0022);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (beat_q.size() !== 1) begin
            failures++;
            $display("FAIL drop_next_count got=%0d expected 1", beat_q.size());
        end else if (beat_q[0].ch !== 4'd0 || beat_q[0].data !== 128'h00000022_00000011 ||
                     beat_q[0].keep !== 4'b0011 || beat_q[0].last !== 1'b1) begin
            failures++;
            $display("FAIL drop_next_beat ch=%0d data=%h keep=%b last=%b expected ch=0 data=22,11 keep=0011 last=1",
                     beat_q[0].ch, beat_q[0].data, beat_q[0].keep, beat_q[0].last);
        end
        checks++;
        if (status[15:8] !== 8'd3 || status[3] !== 1'b1) begin
            failures++;
            $display("FAIL drop_next_status pkt_in=%0d err=%b expected 3 1", status[15:8], status[3]);
        end
    endtask

    task automatic test_backpressure();
        int bad_rd = 0;
        int bad_beat = 0;
        ch_in_ready = 4'b0000;
        beat_q.delete();
        fifo_send(32'h2000_0004);
        for (int k = 0; k < 4; k++) fifo_send(32'hA0 + 32'(k));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rd !== 1'b0) bad_rd++;
            if (ch_in_valid !== 4'b0100 || ch_in_data !== 128'h000000A3_000000A2_000000A1_000000A0 ||
                ch_in_keep !== 4'b1111 || ch_in_last !== 1'b1) bad_beat++;
        end
        @(posedge clk);
        #1 ch_in_ready = 4'b0100;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bad_rd !== 0) begin
            failures++;
            $display("FAIL bp_read_low cycles_with_read=%0d expected 0", bad_rd);
        end
        checks++;
        if (bad_beat !== 0) begin
            failures++;
            $display("FAIL bp_beat_stable unstable_cycles=%0d expected 0", bad_beat);
        end
        checks++;
        if (beat_q.size() !== 1) begin
            failures++;
            $display("FAIL bp_deliver_count got=%0d expected 1", beat_q.size());
        end else if (beat_q[0].ch !== 4'd2 || beat_q[0].data !== 128'h000000A3_000000A2_000000A1_000000A0) begin
            failures++;
            $display("FAIL bp_deliver_beat ch=%0d data=%h expected ch=2 data=A3,A2,A1,A0",
                     beat_q[0].ch, beat_q[0].data);
        end
        checks++;
        if (status[15:8] !== 8'd4) begin
            failures++;
            $display("FAIL bp_pkt_in got=%0d expected 4", status[15:8]);
        end
    endtask

    task automatic test_egress_rr();
        int hb;
        logic [31:0] exp_w [6];
        exp_w = '{32'hC000_0000, 32'hC000_0001, 32'hC000_0002,
                  32'hF300_0000, 32'hF300_0001, 32'hF300_0002};
        wr_wait = 1'b0;
        wr_q.delete();
        for (int i = 0; i < NUM_CH; i++) begin
            src_n[i] = 0;
            src_p[i] = 0;
        end
        src_n[0] = 3;
        src_n[3] = 3;
        for (int k = 0; k < 3; k++) begin
            src_w[0][k] = 32'hC000_0000 + 32'(k);
            src_w[3][k] = 32'hF300_0000 + 32'(k);
        end
        drive_src();
        run_egress(-1, 0, 32'd0, hb);
        checks++;
        if (wr_q.size() !== 6) begin
            failures++;
            $display("FAIL rr_write_count got=%0d expected 6", wr_q.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (wr_q[k] !== exp_w[k]) begin
                    failures++;
                    $display("FAIL rr_word%0d got=%08h expected %08h", k, wr_q[k], exp_w[k]);
                end
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (status[23:16] !== 8'd2 || status[2] !== 1'b0 || wr !== 1'b0) begin
            failures++;
            $display("FAIL rr_status pkt_out=%0d busy=%b write=%b expected 2 0 0",
                     status[23:16], status[2], wr);
        end
    endtask

    task automatic test_egress_stall();
        int hb;
        wr_wait = 1'b0;
        wr_q.delete();
        for (int i = 0; i < NUM_CH; i++) begin
            src_n[i] = 0;
            src_p[i] = 0;
        end
        src_n[1] = 3;
        for (int k = 0; k < 3; k++) src_w[1][k] = 32'hB100_0001 + 32'(k);
        drive_src();
        run_egress(1, 5, 32'hB100_0002, hb);
        checks++;
        if (hb !== 0) begin
            failures++;
            $display("FAIL stall_hold bad_cycles=%0d expected 0", hb);
        end
        checks++;
        if (wr_q.size() !== 3) begin
            failures++;
            $display("FAIL stall_write_count got=%0d expected 3", wr_q.size());
        end else if (wr_q[0] !== 32'hB100_0001 || wr_q[1] !== 32'hB100_0002 || wr_q[2] !== 32'hB100_0003) begin
            failures++;
            $display("FAIL stall_words got=%08h %08h %08h expected B1000001 B1000002 B1000003",
                     wr_q[0], wr_q[1], wr_q[2]);
        end
        checks++;
        if (status[23:16] !== 8'd3) begin
            failures++;
            $display("FAIL stall_pkt_out got=%0d expected 3", status[23:16]);
        end
    endtask

    task automatic test_reset_mid();
        ch_in_ready = 4'b0001;
        fifo_send(32'h0000_0004);
        fifo_send(32'h0000_0001);
        fifo_send(32'h0000_0002);
        checks++;
        if (status[1:0] !== 2'd1) begin
            failures++;
            $display("FAIL mid_in_pay state=%0d expected 1", status[1:0]);
        end
        reset_dut();
        checks++;
        if (rd !== 1'b0 || wr !== 1'b0 || ch_in_valid !== '0 || ch_out_ready !== '0 ||
            ch_in_data !== '0 || ch_in_keep !== '0 || ch_in_last !== 1'b0 || wr_data !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs read=%b write=%b valid=%b ready=%b keep=%b last=%b expected all 0",
                     rd, wr, ch_in_valid, ch_out_ready, ch_in_keep, ch_in_last);
        end
        checks++;
        if (status !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset_status got=%08h expected 00000000", status);
        end
        beat_q.delete();
        fifo_send(32'h0000_0001);
        fifo_send(32'h0000_0099);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (beat_q.size() !== 1) begin
            failures++;
            $display("FAIL mid_fresh_count got=%0d expected 1", beat_q.size());
        end else if (beat_q[0].ch !== 4'd0 || beat_q[0].data !== 128'h99 ||
                     beat_q[0].keep !== 4'b0001 || beat_q[0].last !== 1'b1) begin
            failures++;
            $display("FAIL mid_fresh_beat ch=%0d data=%h keep=%b last=%b expected ch=0 data=99 keep=0001 last=1",
                     beat_q[0].ch, beat_q[0].data, beat_q[0].keep, beat_q[0].last);
        end
        checks++;
        if (status[15:8] !== 8'd1) begin
            failures++;
            $display("FAIL mid_pkt_in got=%0d expected 1", status[15:8]);
        end
    endtask

    initial begin
        rst          = 1'b1;
        rd_data      = 32'd0;
        rd_wait      = 1'b1;
        wr_wait      = 1'b0;
        ch_in_ready  = '0;
        ch_out_data  = '0;
        ch_out_last  = '0;
        ch_out_valid = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            src_n[i] = 0;
            src_p[i] = 0;
        end
        test_reset();
        test_ingress_pack();
        test_drop();
        test_backpressure();
        test_egress_rr();
        test_egress_stall();
        test_reset_mid();
        checks++;
        if (onehot_bad !== 0) begin
            failures++;
            $display("FAIL valid_onehot bad_cycles=%0d expected 0", onehot_bad);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish by 100000 time units");
        $fatal(1, "watchdog");
    end

endmodule
